// File: rtl/mac_dot_accum.sv
// Pipelined multiply-accumulate engine that reduces framed operand streams to one dot product per frame.
// The pipeline runs S1 (product), S2 (accumulate) and then the output register, behind a valid/ready output.
module mac_dot_accum #(
    parameter int A_W      = 8,
    parameter int B_W      = 8,
    parameter int ACC_W    = 20,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam int P_W = A_W + B_W;

    if (ACC_W < P_W) begin : g_bad_width
        $error("mac_dot_accum: ACC_W (%0d) must be >= A_W+B_W (%0d)", ACC_W, P_W);
    end

    function automatic logic [P_W-1:0] mul_op(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        logic signed [P_W-1:0] ea;
        logic signed [P_W-1:0] eb;
        logic signed [P_W-1:0] pr;
        ea = {{B_W{(SIGNED != 0) & a[A_W-1]}}, a};
        eb = {{A_W{(SIGNED != 0) & b[B_W-1]}}, b};
        pr = ea * eb;
        return pr;
    endfunction

    function automatic logic [ACC_W:0] ext_prod(input logic [P_W-1:0] p);
        logic fill;
        fill = (SIGNED != 0) & p[P_W-1];
        return {{(ACC_W + 1 - P_W){fill}}, p};
    endfunction

    function automatic logic [ACC_W:0] ext_acc(input logic [ACC_W-1:0] a);
        return {(SIGNED != 0) & a[ACC_W-1], a};
    endfunction

    function automatic logic ovf_detect(input logic [ACC_W:0] s);
        if (SIGNED != 0) return s[ACC_W] ^ s[ACC_W-1];
        return s[ACC_W];
    endfunction

    function automatic logic [ACC_W-1:0] sat_result(input logic [ACC_W:0] s, input logic ovf);
        if (!ovf || SATURATE == 0) return s[ACC_W-1:0];
        if (SIGNED == 0) return {ACC_W{1'b1}};
        // The extra sum bit is the true sign, so it picks which bound was crossed.
        if (s[ACC_W]) return {1'b1, {(ACC_W - 1){1'b0}}};
        return {1'b0, {(ACC_W - 1){1'b1}}};
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        if (&c) return c;
        return c + 1'b1;
    endfunction

    logic             stall;
    logic             advance;
    logic             out_load;

    logic             vld_p1;
    logic             last_p1;
    logic [P_W-1:0]   prod_p1;

    logic [ACC_W-1:0] acc_p2;
    logic [CNT_W-1:0] cnt_p2;
    logic             sticky_p2;
    logic             vld_p2;
    logic [ACC_W-1:0] res_p2;
    logic [CNT_W-1:0] fcnt_p2;
    logic             fovf_p2;

    logic [ACC_W:0]   sum;
    logic             ovf;
    logic [ACC_W-1:0] result;
    logic [CNT_W-1:0] cnt_next;
    logic             sticky_next;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ena & ~stall & ~clr;
    assign advance  = ena & ~stall & ~clr;
    assign out_load = advance & vld_p2;

    always_comb begin
        sum         = ext_acc(acc_p2) + ext_prod(prod_p1);
        ovf         = ovf_detect(sum);
        result      = sat_result(sum, ovf);
        cnt_next    = cnt_inc(cnt_p2);
        sticky_next = sticky_p2 | ovf;
    end

    // Control and architectural state: valids, accumulator, counter, sticky flag, output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            vld_p2    <= 1'b0;
            acc_p2    <= '0;
            cnt_p2    <= '0;
            sticky_p2 <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (clr) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            acc_p2    <= '0;
            cnt_p2    <= '0;
            sticky_p2 <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (advance) begin
                // S1 boundary
                vld_p1  <= in_valid;
                last_p1 <= in_last;
                // S2 boundary: only frame-final sums travel on to the output register
                vld_p2  <= vld_p1 & last_p1;
                if (vld_p1) begin
                    if (last_p1) begin
                        acc_p2    <= '0;
                        cnt_p2    <= '0;
                        sticky_p2 <= 1'b0;
                    end else begin
                        acc_p2    <= result;
                        cnt_p2    <= cnt_next;
                        sticky_p2 <= sticky_next;
                    end
                end
            end
            // Output boundary
            if (out_load) begin
                out_valid <= 1'b1;
                out_acc   <= res_p2;
                out_count <= fcnt_p2;
                out_ovf   <= fovf_p2;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Datapath registers are qualified by the valids and need no reset.
    always_ff @(posedge clk) begin
        if (advance) begin
            prod_p1 <= mul_op(in_a, in_b);
            res_p2  <= result;
            fcnt_p2 <= cnt_next;
            fovf_p2 <= sticky_next;
        end
    end

endmodule

// File: tb/tb_mac_dot_accum.sv
// Directed bench for mac_dot_accum: four configurations share one stimulus stream,
// and each scenario task checks the instance whose configuration it targets.
module tb_mac_dot_accum;

    logic        clk = 1'b0;
    logic        rst_n, ena, clr, in_valid, in_last, out_ready;
    logic [7:0]  in_a, in_b;

    logic        d_ready, d_valid, d_ovf;
    logic [19:0] d_acc;
    logic [7:0]  d_cnt;
    logic        s_ready, s_valid, s_ovf;
    logic [15:0] s_acc;
    logic [7:0]  s_cnt;
    logic        w_ready, w_valid, w_ovf;
    logic [15:0] w_acc;
    logic [7:0]  w_cnt;
    logic        g_ready, g_valid, g_ovf;
    logic [19:0] g_acc;
    logic [7:0]  g_cnt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mac_dot_accum u_dflt (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .in_valid(in_valid), .in_ready(d_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(d_valid), .out_ready(out_ready),
        .out_acc(d_acc), .out_count(d_cnt), .out_ovf(d_ovf));

    mac_dot_accum #(.ACC_W(16), .SATURATE(1)) u_sat16 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .in_valid(in_valid), .in_ready(s_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(s_valid), .out_ready(out_ready),
        .out_acc(s_acc), .out_count(s_cnt), .out_ovf(s_ovf));

    mac_dot_accum #(.ACC_W(16), .SATURATE(0)) u_wrap16 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .in_valid(in_valid), .in_ready(w_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(w_valid), .out_ready(out_ready),
        .out_acc(w_acc), .out_count(w_cnt), .out_ovf(w_ovf));

    mac_dot_accum #(.SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .in_valid(in_valid), .in_ready(g_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(g_valid), .out_ready(out_ready),
        .out_acc(g_acc), .out_count(g_cnt), .out_ovf(g_ovf));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; ena = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1; in_a = 8'd0; in_b = 8'd0;
        #2 rst_n = 1'b0;
        #10;
        checks++; if (d_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", d_valid); end
        checks++; if (d_acc !== 20'd0) begin fails++; $display("FAIL reset_acc: got %0d expected 0", d_acc); end
        checks++; if (d_cnt !== 8'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", d_cnt); end
        checks++; if (d_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %0b expected 0", d_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_unsigned();
        beat(8'd3, 8'd4, 1'b0);
        beat(8'd5, 8'd6, 1'b0);
        beat(8'd7, 8'd8, 1'b1);
        checks++; if (d_valid !== 1'b0) begin fails++; $display("FAIL uns_lat_n: got %0b expected 0", d_valid); end
        step();
        checks++; if (d_valid !== 1'b0) begin fails++; $display("FAIL uns_lat_n1: got %0b expected 0", d_valid); end
        step();
        checks++; if (d_valid !== 1'b1) begin fails++; $display("FAIL uns_valid: got %0b expected 1", d_valid); end
        checks++; if (d_acc !== 20'd98) begin fails++; $display("FAIL uns_acc: got %0d expected 98", d_acc); end
        checks++; if (d_cnt !== 8'd3) begin fails++; $display("FAIL uns_count: got %0d expected 3", d_cnt); end
        checks++; if (d_ovf !== 1'b0) begin fails++; $display("FAIL uns_ovf: got %0b expected 0", d_ovf); end
        step();
        checks++; if (d_valid !== 1'b0) begin fails++; $display("FAIL uns_pulse: got %0b expected 0", d_valid); end
    endtask

    task automatic test_back_to_back();
        beat(8'd2, 8'd2, 1'b1);
        beat(8'd1, 8'd1, 1'b1);
        step();
        checks++; if (d_valid !== 1'b1 || d_acc !== 20'd4) begin fails++; $display("FAIL b2b_first: got valid=%0b acc=%0d expected valid=1 acc=4", d_valid, d_acc); end
        step();
        checks++; if (d_valid !== 1'b1 || d_acc !== 20'd1) begin fails++; $display("FAIL b2b_second: got valid=%0b acc=%0d expected valid=1 acc=1", d_valid, d_acc); end
        checks++; if (d_cnt !== 8'd1) begin fails++; $display("FAIL b2b_count: got %0d expected 1", d_cnt); end
        step();
        checks++; if (d_valid !== 1'b0) begin fails++; $display("FAIL b2b_end: got %0b expected 0", d_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        beat(8'd1, 8'd2, 1'b1);
        beat(8'd3, 8'd3, 1'b1);
        step();
        checks++; if (d_valid !== 1'b1 || d_acc !== 20'd2) begin fails++; $display("FAIL bp_first: got valid=%0b acc=%0d expected valid=1 acc=2", d_valid, d_acc); end
        checks++; if (d_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %0b expected 0", d_ready); end
        step();
        step();
        checks++; if (d_valid !== 1'b1 || d_acc !== 20'd2 || d_cnt !== 8'd1) begin fails++; $display("FAIL bp_hold: got valid=%0b acc=%0d cnt=%0d expected 1/2/1", d_valid, d_acc, d_cnt); end
        checks++; if (d_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_hold: got %0b expected 0", d_ready); end
        out_ready = 1'b1;
        #1;
        checks++; if (d_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %0b expected 1", d_ready); end
        step();
        checks++; if (d_valid !== 1'b1 || d_acc !== 20'd9 || d_cnt !== 8'd1) begin fails++; $display("FAIL bp_queued: got valid=%0b acc=%0d cnt=%0d expected 1/9/1", d_valid, d_acc, d_cnt); end
        step();
        checks++; if (d_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %0b expected 0", d_valid); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) beat(8'd255, 8'd255, (i == 19));
        step();
        step();
        checks++; if (s_valid !== 1'b1 || s_acc !== 16'hFFFF) begin fails++; $display("FAIL sat_acc: got valid=%0b acc=%h expected 1/ffff", s_valid, s_acc); end
        checks++; if (s_ovf !== 1'b1 || s_cnt !== 8'd20) begin fails++; $display("FAIL sat_flags: got ovf=%0b cnt=%0d expected 1/20", s_ovf, s_cnt); end
        checks++; if (w_valid !== 1'b1 || w_acc !== 16'hD814) begin fails++; $display("FAIL wrap_acc: got valid=%0b acc=%h expected 1/d814", w_valid, w_acc); end
        checks++; if (w_ovf !== 1'b1 || w_cnt !== 8'd20) begin fails++; $display("FAIL wrap_flags: got ovf=%0b cnt=%0d expected 1/20", w_ovf, w_cnt); end
        step();
    endtask

    task automatic test_signed();
        beat(8'hFD, 8'h04, 1'b0);
        beat(8'h02, 8'hFB, 1'b1);
        step();
        step();
        checks++; if (g_valid !== 1'b1 || g_acc !== 20'hFFFEA) begin fails++; $display("FAIL sgn_acc: got valid=%0b acc=%h expected 1/fffea", g_valid, g_acc); end
        checks++; if (g_ovf !== 1'b0 || g_cnt !== 8'd2) begin fails++; $display("FAIL sgn_flags: got ovf=%0b cnt=%0d expected 0/2", g_ovf, g_cnt); end
        checks++; if (d_acc !== 20'd1514) begin fails++; $display("FAIL uns_same_bits: got %0d expected 1514", d_acc); end
        step();
    endtask

    task automatic test_clr();
        beat(8'd1, 8'd1, 1'b0);
        beat(8'd1, 8'd1, 1'b0);
        clr = 1'b1;
        #1;
        checks++; if (d_ready !== 1'b0) begin fails++; $display("FAIL clr_in_ready: got %0b expected 0", d_ready); end
        step();
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (d_valid !== 1'b0) begin fails++; $display("FAIL clr_no_output: got %0b expected 0", d_valid); end
        end
        beat(8'd1, 8'd1, 1'b1);
        step();
        step();
        checks++; if (d_valid !== 1'b1 || d_acc !== 20'd1 || d_cnt !== 8'd1) begin fails++; $display("FAIL clr_next: got valid=%0b acc=%0d cnt=%0d expected 1/1/1", d_valid, d_acc, d_cnt); end
        step();
    endtask

    task automatic test_reset_midframe();
        beat(8'd1, 8'd1, 1'b0);
        beat(8'd1, 8'd1, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (d_valid !== 1'b0 || d_cnt !== 8'd0) begin fails++; $display("FAIL rst_mid: got valid=%0b cnt=%0d expected 0/0", d_valid, d_cnt); end
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (d_valid !== 1'b0) begin fails++; $display("FAIL rst_no_output: got %0b expected 0", d_valid); end
        end
        beat(8'd1, 8'd1, 1'b1);
        step();
        step();
        checks++; if (d_valid !== 1'b1 || d_acc !== 20'd1 || d_cnt !== 8'd1) begin fails++; $display("FAIL rst_next: got valid=%0b acc=%0d cnt=%0d expected 1/1/1", d_valid, d_acc, d_cnt); end
        step();
    endtask

    task automatic test_ena();
        ena = 1'b0;
        #1;
        checks++; if (d_ready !== 1'b0) begin fails++; $display("FAIL ena_in_ready: got %0b expected 0", d_ready); end
        beat(8'd9, 8'd9, 1'b1);
        step();
        step();
        checks++; if (d_valid !== 1'b0) begin fails++; $display("FAIL ena_frozen: got %0b expected 0", d_valid); end
        ena = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_signed();
        test_clr();
        test_reset_midframe();
        test_ena();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
